seq_datapath: RTL and testbench
===============================

Name: seq_datapath

Overview:
- Parametrised successor to the 16-bit, 8-register lab datapath.
- Keeps the regfile, the A/B/C pipeline registers, the shifter, the ALU and the status register.
- Width and register count are generalised, and the status flag grows to Z/N/V.
- Adds an internal micro-sequencer: one instruction is accepted per start/done handshake and stepped through the A/B/C/writeback stages automatically. The external controller no longer drives loada/loadb/loadc/write.

Parameters:
- W, 16, datapath word width (>=8).
- NREG, 8, number of registers (power of 2, >=2).
- AW, $clog2(NREG), register address width (derived).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to execute; sampled only in IDLE.
- op  input  3  0 MOVI, 1 MOV, 2 ADD, 3 CMP, 4 AND, 5 MVN, 6-7 reserved.
- rd, rn, rm  input  AW each  destination register, A-source register, B-source register.
- shift  input  2  applied to the B operand: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
- imm8  input  8  MOVI immediate, sign-extended to W.
- rdaddr  input  AW  debug read address.
- rddata  output  W  combinational R[rdaddr].
- datapath_out  output  W  C register.
- status  output  3  {V,N,Z}, registered.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the instruction completes.
- err  output  1  pulses with done for reserved opcodes.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all R[i], A, B, C and status = 0; busy, done and err = 0.
- Accept: in IDLE with start=1, latch op, rd, rn, rm, shift and imm8 at the edge. start while busy is ignored and does not queue.
- States: IDLE, LDA, LDB, EXEC, WB, DONE.
- Transitions:
  - IDLE -> LDA for ops 1-5.
  - IDLE -> EXEC for MOVI.
  - IDLE -> DONE for reserved ops, with err=1 in DONE.
  - LDA -> LDB -> EXEC -> WB -> DONE -> IDLE.
- LDA edge: A <= R[rn]. LDB edge: B <= R[rm].
- EXEC edge: C <= result; status loaded for ops 1-5, unchanged for MOVI. Results:
  - MOVI: C = sx(imm8).
  - MOV: Bs = shifted B.
  - ADD: A + Bs.
  - CMP: A - Bs.
  - AND: A & Bs.
  - MVN: ~Bs.
- Flags:
  - Z = (result == 0).
  - N = result[W-1].
  - V = signed overflow for ADD/CMP; 0 for MOV/AND/MVN.
  - CMP flags come from the full W-bit subtraction.
- WB edge: R[rd] <= C, except CMP, which performs no register write.
- DONE: done=1 for exactly one cycle, then IDLE. A new start may be sampled in that same DONE->IDLE cycle's following IDLE cycle (no back-to-back acceptance in DONE).
- Latency from the accepting edge to the done-high cycle: ops 1-5 = 5 cycles; MOVI = 3; reserved = 1.
- Arithmetic is modulo 2^W; the carry is discarded.
- Operands are read at LDA/LDB, so rd==rn==rm is legal. The result uses the old values and overwrites at WB.
- rddata reflects a write from the cycle after the WB edge.
- reset_n low in any state aborts the instruction: no partial writeback, everything returns to reset values.
- Reserved op: no register, A/B/C or status change.

Test Plan (W=16, NREG=8):
- MOVI R0,#7 then MOVI R1,#0xFE -> R0=0x0007, R1=0xFFFE; done 3 cycles after each accept; status stays 000.
- MOV R6,R1,LSR1 -> R6=0x7FFF, status {V,N,Z}=000. Then ADD R7,R6,R0,LSL1 -> R7=0x800D, status=110 (V=1,N=1), done 5 cycles after accept.
- CMP R0,R0 -> status=001, no register changes (rddata sweep of R0-R7 unchanged). Then AND R2,R1,R0 -> R2=0x0006, status=000.
- Assert start on every cycle during an ADD -> only one accept; busy high for 5 cycles; a second accept occurs only after done.
- Drop reset_n during EXEC of ADD R3,R0,R0 -> busy=0 immediately (async); R0-R7, status and C read 0; no done pulse.
- op=6 with start -> done=1 and err=1 on the next cycle; regs and status unchanged; busy low afterwards.

Source files
------------

// File: rtl/seq_datapath.sv
// seq_datapath: micro-sequenced register-file datapath with shifter, ALU and {V,N,Z} status.
// Ports: clk/reset_n (async active-low); start + op/rd/rn/rm/shift/imm8 issue one instruction;
// rdaddr/rddata debug read; datapath_out = C; status = {V,N,Z}; busy/done/err handshake.
module seq_datapath #(
  parameter int W = 16,
  parameter int NREG = 8,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rn,
  input  logic [AW-1:0] rm,
  input  logic [1:0]    shift,
  input  logic [7:0]    imm8,
  input  logic [AW-1:0] rdaddr,
  output logic [W-1:0]  rddata,
  output logic [W-1:0]  datapath_out,
  output logic [2:0]    status,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, LDA, LDB, EXEC, WB, DONE} state_t;
  localparam logic [2:0] OP_MOVI = 3'd0, OP_MOV = 3'd1, OP_ADD = 3'd2, OP_CMP = 3'd3, OP_AND = 3'd4, OP_MVN = 3'd5;
  state_t        state_q;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rn_q, rm_q;
  logic [1:0]    shift_q;
  logic [7:0]    imm_q;
  logic [W-1:0]  regs_q [NREG];
  logic [W-1:0]  a_q, b_q, c_q;
  logic [2:0]    status_q;
  logic          busy_q, done_q, err_q;
  logic [W-1:0]  bs_d, sum_d, diff_d, res_d;
  logic          v_d;
  logic [2:0]    status_d;
  assign rddata       = regs_q[rdaddr];
  assign datapath_out = c_q;
  assign status       = status_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  always_comb begin
    bs_d   = shift_q == 2'b01 ? {b_q[W-2:0], 1'b0} :
             shift_q == 2'b10 ? {1'b0, b_q[W-1:1]} :
             shift_q == 2'b11 ? {b_q[W-1], b_q[W-1:1]} : b_q;
    sum_d  = a_q + bs_d;
    diff_d = a_q - bs_d;
    res_d  = op_q == OP_MOVI ? {{(W-8){imm_q[7]}}, imm_q} :
             op_q == OP_MOV  ? bs_d :
             op_q == OP_ADD  ? sum_d :
             op_q == OP_CMP  ? diff_d :
             op_q == OP_AND  ? (a_q & bs_d) :
             op_q == OP_MVN  ? ~bs_d : '0;
    // Overflow: same-sign operands giving an opposite-sign sum; for subtraction the operands differ in sign.
    v_d    = op_q == OP_ADD ? (a_q[W-1] == bs_d[W-1]) && (sum_d[W-1] != a_q[W-1]) :
             op_q == OP_CMP ? (a_q[W-1] != bs_d[W-1]) && (diff_d[W-1] != a_q[W-1]) : 1'b0;
    status_d = {v_d, res_d[W-1], res_d == '0};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= '0;
      imm_q    <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          op_q    <= op;
          rd_q    <= rd;
          rn_q    <= rn;
          rm_q    <= rm;
          shift_q <= shift;
          imm_q   <= imm8;
          busy_q  <= 1'b1;
          state_q <= op == OP_MOVI ? EXEC : op <= OP_MVN ? LDA : DONE;
          // Reserved ops go straight to DONE, so their done/err pulse is raised here.
          done_q  <= op > OP_MVN;
          err_q   <= op > OP_MVN;
        end
        LDA: begin
          a_q     <= regs_q[rn_q];
          state_q <= LDB;
        end
        LDB: begin
          b_q     <= regs_q[rm_q];
          state_q <= EXEC;
        end
        EXEC: begin
          c_q     <= res_d;
          if (op_q != OP_MOVI) status_q <= status_d;
          state_q <= WB;
        end
        WB: begin
          if (op_q != OP_CMP) regs_q[rd_q] <= c_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_datapath.sv
// tb_seq_datapath: directed self-checking bench for seq_datapath (W=16, NREG=8).
module tb_seq_datapath;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op, rd, rn, rm, rdaddr;
  logic [1:0]  shift;
  logic [7:0]  imm8;
  logic [15:0] rddata, datapath_out;
  logic [2:0]  status;
  logic        busy, done, err;
  int          n_assert = 0;
  int          n_fail = 0;

  seq_datapath #(.W(16), .NREG(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .rd(rd), .rn(rn), .rm(rm),
    .shift(shift), .imm8(imm8), .rdaddr(rdaddr), .rddata(rddata), .datapath_out(datapath_out),
    .status(status), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input logic [2:0] a, input logic [15:0] exp, input string tag);
    rdaddr = a;
    #1;
    chk(tag, {16'h0, rddata}, {16'h0, exp});
  endtask

  // Issue one instruction, measure accept-to-done latency, then step into the following IDLE cycle.
  task automatic issue(input logic [2:0] o, d, n, m, input logic [1:0] s, input logic [7:0] i,
                       input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    op = o; rd = d; rn = n; rm = m; shift = s; imm8 = i; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    @(posedge clk);
    #1;
    chk({tag, " idle after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int ndone;
    int lat;
    reset_n = 1'b0; start = 1'b0; op = '0; rd = '0; rn = '0; rm = '0; shift = '0; imm8 = '0; rdaddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done/err", {30'h0, done, err}, 32'h0);
    chk("reset C", {16'h0, datapath_out}, 32'h0);
    chk("reset status", {29'h0, status}, 32'h0);
    for (int a = 0; a < 8; a++) rchk(3'(a), 16'h0, "reset reg");
    @(negedge clk) reset_n = 1'b1;

    issue(3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 8'h07, 3, "MOVI R0");
    rchk(3'd0, 16'h0007, "R0 after MOVI");
    chk("MOVI C", {16'h0, datapath_out}, 32'h0007);
    issue(3'd0, 3'd1, 3'd0, 3'd0, 2'b00, 8'hFE, 3, "MOVI R1");
    rchk(3'd1, 16'hFFFE, "R1 after MOVI");
    chk("MOVI status", {29'h0, status}, 32'h0);

    issue(3'd1, 3'd6, 3'd0, 3'd1, 2'b10, 8'h00, 5, "MOV LSR1");
    rchk(3'd6, 16'h7FFF, "R6 after MOV");
    chk("MOV status", {29'h0, status}, 32'h0);
    issue(3'd2, 3'd7, 3'd6, 3'd0, 2'b01, 8'h00, 5, "ADD LSL1");
    rchk(3'd7, 16'h800D, "R7 after ADD");
    chk("ADD status", {29'h0, status}, 32'h6);

    issue(3'd3, 3'd5, 3'd0, 3'd0, 2'b00, 8'h00, 5, "CMP");
    chk("CMP status", {29'h0, status}, 32'h1);
    chk("CMP C", {16'h0, datapath_out}, 32'h0);
    rchk(3'd0, 16'h0007, "CMP sweep R0");
    rchk(3'd1, 16'hFFFE, "CMP sweep R1");
    rchk(3'd2, 16'h0000, "CMP sweep R2");
    rchk(3'd3, 16'h0000, "CMP sweep R3");
    rchk(3'd4, 16'h0000, "CMP sweep R4");
    rchk(3'd5, 16'h0000, "CMP sweep R5");
    rchk(3'd6, 16'h7FFF, "CMP sweep R6");
    rchk(3'd7, 16'h800D, "CMP sweep R7");
    issue(3'd4, 3'd2, 3'd1, 3'd0, 2'b00, 8'h00, 5, "AND");
    rchk(3'd2, 16'h0006, "R2 after AND");
    chk("AND status", {29'h0, status}, 32'h0);

    // start held high through a whole ADD: one accept, then a re-accept only after DONE.
    @(negedge clk);
    op = 3'd2; rd = 3'd4; rn = 3'd0; rm = 3'd0; shift = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      chk("held busy", {31'h0, busy}, 32'h1);
      if (done) ndone++;
    end
    chk("held done count", ndone, 1);
    @(posedge clk);
    #1;
    chk("held idle gap", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    chk("held reaccept", {31'h0, busy}, 32'h1);
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("held second latency", lat, 1'b1 ? 5 : 0);
    @(posedge clk);
    #1;
    rchk(3'd4, 16'h000E, "R4 after ADD");
    chk("R4 ADD status", {29'h0, status}, 32'h0);

    // Reset dropped while ADD R3,R0,R0 sits in EXEC.
    @(negedge clk);
    op = 3'd2; rd = 3'd3; rn = 3'd0; rm = 3'd0; shift = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort busy", {31'h0, busy}, 32'h0);
    chk("abort status", {29'h0, status}, 32'h0);
    chk("abort C", {16'h0, datapath_out}, 32'h0);
    for (int a = 0; a < 8; a++) rchk(3'(a), 16'h0, "abort reg");
    @(posedge clk);
    #1;
    chk("abort no done", {31'h0, done}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort no late done", ndone, 0);

    // Reserved opcode: immediate done+err, no state change.
    issue(3'd0, 3'd5, 3'd0, 3'd0, 2'b00, 8'h80, 3, "MOVI R5");
    rchk(3'd5, 16'hFF80, "R5 after MOVI");
    issue(3'd3, 3'd0, 3'd5, 3'd0, 2'b00, 8'h00, 5, "CMP R5,R0");
    chk("CMP N status", {29'h0, status}, 32'h2);
    @(negedge clk);
    op = 3'd6; rd = 3'd5; rn = 3'd5; rm = 3'd5; imm8 = 8'h01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("reserved done", {31'h0, done}, 32'h1);
    chk("reserved err", {31'h0, err}, 32'h1);
    @(posedge clk);
    #1;
    chk("reserved busy after", {31'h0, busy}, 32'h0);
    chk("reserved pulse end", {30'h0, done, err}, 32'h0);
    chk("reserved status", {29'h0, status}, 32'h2);
    chk("reserved C", {16'h0, datapath_out}, 32'hFF80);
    rchk(3'd5, 16'hFF80, "reserved R5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
